uart_rx_frame: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_frame_if.sv | 28 ++
 rtl/uart_rx_sync.sv | 66 ++++++
 rtl/uart_rx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_rx_frame receiver.
//   - uart_state_e : receiver state encoding (IDLE, START, DATA, PARITY, STOP)
//   - PAR_*        : parity mode encodings used by the PARITY parameter
//   - baud_cnt()   : clocks per bit from clock in MHz and line rate in bit/s
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Integer clocks per bit; the fractional remainder is dropped.
  function automatic int baud_cnt(input int clk_mhz, input int baud);
    baud_cnt = (clk_mhz * 32'sd1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line plus received-frame outputs of the receiver.
//   rx_in      : serial line into the receiver (idles high)
//   rx_data    : received word, DATA_BITS wide
//   rx_valid   : one-cycle pulse, rx_data and error flags valid
//   parity_err : parity mismatch on the last frame
//   frame_err  : stop bit sampled low on the last frame
//   rx_busy    : receiver is inside a frame
// master = the receiver, slave = the consumer of received frames.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    input  rx_in,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    output rx_in,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous rx_in into the clk domain.
//   clk, rst  : system clock, synchronous active-high reset
//   rx_in     : raw serial line
//   rxs       : 2-flop synchronised line (used for start-edge detection)
//   rxs_vote  : value to use at sample points
// Optional build macro UART_RX_MAJORITY_EN: rxs_vote is the majority of the
// current rxs and its two previous values; otherwise rxs_vote equals rxs.
// Both variants present the vote in the same cycle, so sample timing matches.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rxs,
  output logic rxs_vote
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Next-state of the synchroniser chain.
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops; reset to the idle-line level so no edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // Two previous rxs values; with the current rxs they form a 3-sample window.
  logic [1:0] hist_q, hist_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Shift the synced line into the history window.
  always_comb begin
    hist_d = {hist_q[0], sync2_q};
  end

  // History flops, reset to idle-line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rxs_vote = maj3(sync2_q, hist_q[0], hist_q[1]);
`else
  assign rxs_vote = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits).
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_rx_frame_if.master (rx_in in; rx_data, rx_valid,
//              parity_err, frame_err, rx_busy out, all registered)
// Optional build macro UART_RX_MAJORITY_EN (see uart_rx_sync): majority-vote
// sampling. Default build samples the synced line directly.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic             clk,
  input logic             rst,
  uart_rx_frame_if.master bus
);

  localparam int BAUD_CNT = baud_cnt(CLK_FREQ, BAUD_RATE);
  localparam int HALF     = BAUD_CNT / 2;
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BAUD_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE      = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST    = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_START  = 3'(ST_START);
  localparam logic [2:0] S_DATA   = 3'(ST_DATA);
  localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
  localparam logic [2:0] S_STOP   = 3'(ST_STOP);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_rx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT < 8) begin : g_bad_baud
      $error("uart_rx_frame: CLK_FREQ/BAUD_RATE gives fewer than 8 clocks per bit");
    end
  endgenerate

  // 1 when the received parity bit disagrees with the configured mode.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic sample);
    logic ones_odd;
    ones_odd = ^{data, sample};
    case (PARITY)
      PAR_ODD:  parity_bad = ~ones_odd;
      PAR_EVEN: parity_bad = ones_odd;
      default:  parity_bad = 1'b0;
    endcase
  endfunction

  logic rxs, rxs_vote;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (bus.rx_in),
    .rxs      (rxs),
    .rxs_vote (rxs_vote)
  );

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pe_pend_q, pe_pend_d;
  logic                 fe_pend_q, fe_pend_d;
  logic                 rxs_prev_q, rxs_prev_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_busy_q, rx_busy_d;

  // Receiver state machine and output staging.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    pe_pend_d    = pe_pend_q;
    fe_pend_d    = fe_pend_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;
    rxs_prev_d   = rxs;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        // Falling edge only: a line stuck low after a break cannot re-trigger.
        if (rxs_prev_q && !rxs) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = CNT_ZERO;
          if (rxs_vote) begin
            state_d = S_IDLE;  // line back high at mid start bit: glitch
          end else begin
            state_d   = S_DATA;
            idx_d     = IDX_ZERO;
            pe_pend_d = 1'b0;
            fe_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d          = CNT_ZERO;
          shift_d[idx_q] = rxs_vote;
          if (idx_q == IDX_LAST) begin
            idx_d  = IDX_ZERO;
            stop_d = 1'b0;
            if (PARITY != PAR_NONE) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d     = CNT_ZERO;
          pe_pend_d = parity_bad(shift_q, rxs_vote);
          stop_d    = 1'b0;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = CNT_ZERO;
          if (!rxs_vote) begin
            fe_pend_d = 1'b1;
          end else begin
            fe_pend_d = fe_pend_q;
          end
          // Leave at mid last stop bit so a start edge half a bit later is caught.
          if (stop_q == STOP_LAST) begin
            state_d      = S_IDLE;
            stop_d       = 1'b0;
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = pe_pend_q;
            frame_err_d  = fe_pend_q | ~rxs_vote;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      idx_q        <= IDX_ZERO;
      stop_q       <= 1'b0;
      shift_q      <= {DATA_BITS{1'b0}};
      pe_pend_q    <= 1'b0;
      fe_pend_q    <= 1'b0;
      rxs_prev_q   <= 1'b1;
      rx_data_q    <= {DATA_BITS{1'b0}};
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      pe_pend_q    <= pe_pend_d;
      fe_pend_q    <= fe_pend_d;
      rxs_prev_q   <= rxs_prev_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = rx_busy_q;

endmodule
